// File: rtl/float_to_int_pkg.sv
// Shared types and constants for the binary32 to int32 converter.
// Decoded float layout, operand classes, integer limits and flag bit positions.
package float_to_int_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    typedef enum logic [1:0] {
        CLS_NUM = 2'd0,
        CLS_NAN = 2'd1,
        CLS_OVF = 2'd2,
        CLS_MIN = 2'd3
    } f2i_class_e;

    localparam logic [7:0]  EXP_BIAS  = 8'd127;
    localparam logic [7:0]  EXP_HALF  = EXP_BIAS - 8'd1;
    localparam logic [7:0]  EXP_EXACT = EXP_BIAS + 8'd23;
    localparam logic [7:0]  EXP_OVF   = EXP_BIAS + 8'd31;
    localparam logic [7:0]  EXP_SPEC  = 8'hFF;

    localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] NAN_RESULT = 32'h8000_0000;

    localparam int FLAG_W        = 3;
    localparam int FLAG_INEXACT  = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INVALID  = 2;

    // -2^31 is the one magnitude >= 2^31 that still fits, so it gets its own class.
    function automatic f2i_class_e classify(input float_t f);
        if (f.exp == EXP_SPEC && f.man != '0) begin
            return CLS_NAN;
        end
        if (f.sign && f.exp == EXP_OVF && f.man == '0) begin
            return CLS_MIN;
        end
        if (f.exp >= EXP_OVF) begin
            return CLS_OVF;
        end
        return CLS_NUM;
    endfunction

endpackage

// File: rtl/float_to_int_if.sv
// Operand/result handshake bundle between the register slave and the converter core.
interface float_to_int_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    modport master (
        output in_valid,
        output in_data,
        output in_rnd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_flags
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_rnd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_flags
    );

endinterface

// File: rtl/f2i_align_shift.sv
// Aligns the 24-bit significand to an integer magnitude for a given biased exponent,
// returning the first discarded bit (guard) and the OR of the rest (sticky).
module f2i_align_shift
    import float_to_int_pkg::*;
(
    input  logic [23:0] sig,
    input  logic [7:0]  exp,
    output logic [31:0] mag,
    output logic        guard,
    output logic        sticky
);

    logic [2:0]  lsh;
    logic [4:0]  rsh;
    logic [47:0] rext;

    // Only low bits are needed: exp-150 is 0..7 and 150-exp is 1..23 where each is used.
    assign lsh  = exp[2:0] - EXP_EXACT[2:0];
    assign rsh  = EXP_EXACT[4:0] - exp[4:0];
    assign rext = {sig, 24'h0} >> rsh;

    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (exp == 8'd0) begin
            sticky = |sig[22:0];
        end else if (exp >= EXP_EXACT) begin
            mag = {8'h0, sig} << lsh;
        end else if (exp >= EXP_BIAS) begin
            mag    = {8'h0, rext[47:24]};
            guard  = rext[23];
            sticky = |rext[22:0];
        end else begin
            guard  = (exp == EXP_HALF);
            sticky = (exp != EXP_HALF) | (|sig[22:0]);
        end
    end

endmodule

// File: rtl/float_to_int_core.sv
// Three-stage binary32 to signed int32 converter: decode/classify, align, round/negate.
// One global advance enable freezes every stage while the result stage is refused.
module float_to_int_core
    import float_to_int_pkg::*;
(
    input  logic         ACLK,
    input  logic         ARESETN,
    float_to_int_if.slave io
);

    logic              adv;

    logic              v1_q, v1_d;
    float_t            f1_q, f1_d;
    f2i_class_e        cls1_q, cls1_d;
    logic              rnd1_q, rnd1_d;

    logic              v2_q, v2_d;
    logic [31:0]       mag2_q, mag2_d;
    logic              guard2_q, guard2_d;
    logic              sticky2_q, sticky2_d;
    logic              sign2_q, sign2_d;
    f2i_class_e        cls2_q, cls2_d;
    logic              rnd2_q, rnd2_d;

    logic              v3_q, v3_d;
    logic [31:0]       data3_q, data3_d;
    logic [FLAG_W-1:0] flags3_q, flags3_d;

    logic [31:0]       al_mag;
    logic              al_guard;
    logic              al_sticky;

    logic              rnd_inc;
    logic [31:0]       mag_rnd;
    logic [31:0]       res_data;
    logic [FLAG_W-1:0] res_flags;

    f2i_align_shift u_align (
        .sig    ({1'b1, f1_q.man}),
        .exp    (f1_q.exp),
        .mag    (al_mag),
        .guard  (al_guard),
        .sticky (al_sticky)
    );

    // Magnitude is below 2^24 whenever rounding applies, so the increment cannot overflow.
    always_comb begin
        rnd_inc   = rnd2_q & guard2_q & (sticky2_q | mag2_q[0]);
        mag_rnd   = mag2_q + {31'h0, rnd_inc};
        res_data  = sign2_q ? -mag_rnd : mag_rnd;
        res_flags = '0;
        case (cls2_q)
            CLS_NAN: begin
                res_data                = NAN_RESULT;
                res_flags[FLAG_INVALID] = 1'b1;
            end
            CLS_OVF: begin
                res_data                 = sign2_q ? INT_MIN : INT_MAX;
                res_flags[FLAG_OVERFLOW] = 1'b1;
            end
            CLS_MIN: begin
                res_data = INT_MIN;
            end
            default: begin
                res_flags[FLAG_INEXACT] = guard2_q | sticky2_q;
            end
        endcase
    end

    always_comb begin
        adv       = !(v3_q && !io.out_ready);

        v1_d      = v1_q;
        f1_d      = f1_q;
        cls1_d    = cls1_q;
        rnd1_d    = rnd1_q;
        v2_d      = v2_q;
        mag2_d    = mag2_q;
        guard2_d  = guard2_q;
        sticky2_d = sticky2_q;
        sign2_d   = sign2_q;
        cls2_d    = cls2_q;
        rnd2_d    = rnd2_q;
        v3_d      = v3_q;
        data3_d   = data3_q;
        flags3_d  = flags3_q;

        if (adv) begin
            v1_d      = io.in_valid;
            f1_d      = float_t'(io.in_data);
            cls1_d    = classify(float_t'(io.in_data));
            rnd1_d    = io.in_rnd;

            v2_d      = v1_q;
            mag2_d    = al_mag;
            guard2_d  = al_guard;
            sticky2_d = al_sticky;
            sign2_d   = f1_q.sign;
            cls2_d    = cls1_q;
            rnd2_d    = rnd1_q;

            v3_d      = v2_q;
            data3_d   = res_data;
            flags3_d  = res_flags;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            v1_q      <= 1'b0;
            f1_q      <= '0;
            cls1_q    <= CLS_NUM;
            rnd1_q    <= 1'b0;
            v2_q      <= 1'b0;
            mag2_q    <= '0;
            guard2_q  <= 1'b0;
            sticky2_q <= 1'b0;
            sign2_q   <= 1'b0;
            cls2_q    <= CLS_NUM;
            rnd2_q    <= 1'b0;
            v3_q      <= 1'b0;
            data3_q   <= '0;
            flags3_q  <= '0;
        end else begin
            v1_q      <= v1_d;
            f1_q      <= f1_d;
            cls1_q    <= cls1_d;
            rnd1_q    <= rnd1_d;
            v2_q      <= v2_d;
            mag2_q    <= mag2_d;
            guard2_q  <= guard2_d;
            sticky2_q <= sticky2_d;
            sign2_q   <= sign2_d;
            cls2_q    <= cls2_d;
            rnd2_q    <= rnd2_d;
            v3_q      <= v3_d;
            data3_q   <= data3_d;
            flags3_q  <= flags3_d;
        end
    end

    assign io.in_ready  = adv;
    assign io.out_valid = v3_q;
    assign io.out_data  = data3_q;
    assign io.out_flags = flags3_q;

endmodule
